// File: rtl/led_matrix_scanner_if.sv
// Bundle between game logic and the LED matrix scanner: back-buffer writes,
// swap handshake, and the scanned row/column drive lines.
interface led_matrix_scanner_if;
  logic       wr_en;
  logic [2:0] wr_x;
  logic [2:0] wr_y;
  logic [2:0] wr_rgb;
  logic       clr;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_start;
  logic [2:0] comm;
  logic       enable;
  logic [7:0] LedR;
  logic [7:0] LedG;
  logic [7:0] LedB;

  modport master (
    output wr_en, wr_x, wr_y, wr_rgb, clr, swap_req,
    input  swap_ack, frame_start, comm, enable, LedR, LedG, LedB
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_rgb, clr, swap_req,
    output swap_ack, frame_start, comm, enable, LedR, LedG, LedB
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 RGB frame store with row-multiplexed, blanked scan-out.
// Front/back swap is deferred to the frame boundary so no half-updated map shows.
module led_matrix_scanner #(
  parameter int ROW_TICKS   = 50000,
  parameter int BLANK_TICKS = 16
) (
  input logic               SYS_CLK,
  input logic               RST,
  led_matrix_scanner_if.slave bus
);

  localparam int CNT_W = $clog2(ROW_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ROW_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_TICKS);

  // Clear-then-write of one row of one colour plane.
  function automatic logic [7:0] row_update(
    input logic [7:0] cur,
    input logic       clear,
    input logic       hit,
    input logic [2:0] col,
    input logic       val
  );
    logic [7:0] row;
    row = clear ? 8'h00 : cur;
    if (hit) row[col] = val;
    return row;
  endfunction

  // Active-low column drive; blanked rows float all columns high.
  function automatic logic [7:0] col_drive(input logic lit, input logic [7:0] plane);
    return lit ? ~plane : 8'hFF;
  endfunction

  // Frame store: [buffer][row][column] per colour plane.
  logic [1:0][7:0][7:0] plane_r;
  logic [1:0][7:0][7:0] plane_g;
  logic [1:0][7:0][7:0] plane_b;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       comm;
  logic             front_sel;
  logic             pending;
  logic             swap_ack;
  logic             frame_start;
  logic             enable;
  logic [7:0]       led_r;
  logic [7:0]       led_g;
  logic [7:0]       led_b;

  logic             back_sel;
  logic             row_end;
  logic             boundary;
  logic             do_swap;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       comm_nxt;
  logic             front_sel_nxt;
  logic             enable_nxt;
  logic [7:0][7:0]  back_r_nxt;
  logic [7:0][7:0]  back_g_nxt;
  logic [7:0][7:0]  back_b_nxt;

  // Scan timing and swap decision, evaluated one cycle ahead so the
  // registered outputs line up with the registered comm/cnt.
  always_comb begin
    back_sel      = ~front_sel;
    row_end       = (cnt == CNT_LAST);
    boundary      = row_end && (comm == 3'd7);
    do_swap       = boundary && (pending || bus.swap_req);
    cnt_nxt       = row_end ? '0 : cnt + CNT_W'(1);
    comm_nxt      = row_end ? comm + 3'd1 : comm;
    front_sel_nxt = front_sel ^ do_swap;
    enable_nxt    = (cnt_nxt >= CNT_BLANK);
  end

  // Back-buffer update; targets the buffer that is back before any swap this cycle.
  always_comb begin
    back_r_nxt = '0;
    back_g_nxt = '0;
    back_b_nxt = '0;
    for (int r = 0; r < 8; r++) begin
      back_r_nxt[r] = row_update(plane_r[back_sel][r], bus.clr,
                                 bus.wr_en && (bus.wr_x == 3'(r)), bus.wr_y, bus.wr_rgb[2]);
      back_g_nxt[r] = row_update(plane_g[back_sel][r], bus.clr,
                                 bus.wr_en && (bus.wr_x == 3'(r)), bus.wr_y, bus.wr_rgb[1]);
      back_b_nxt[r] = row_update(plane_b[back_sel][r], bus.clr,
                                 bus.wr_en && (bus.wr_x == 3'(r)), bus.wr_y, bus.wr_rgb[0]);
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      plane_r     <= '0;
      plane_g     <= '0;
      plane_b     <= '0;
      cnt         <= '0;
      comm        <= 3'd0;
      front_sel   <= 1'b0;
      pending     <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      enable      <= 1'b0;
      led_r       <= 8'hFF;
      led_g       <= 8'hFF;
      led_b       <= 8'hFF;
    end else begin
      plane_r[back_sel] <= back_r_nxt;
      plane_g[back_sel] <= back_g_nxt;
      plane_b[back_sel] <= back_b_nxt;
      cnt         <= cnt_nxt;
      comm        <= comm_nxt;
      front_sel   <= front_sel_nxt;
      // A request seen on the boundary is consumed by that boundary's swap.
      pending     <= boundary ? 1'b0 : (pending || bus.swap_req);
      swap_ack    <= do_swap;
      frame_start <= boundary;
      enable      <= enable_nxt;
      led_r       <= col_drive(enable_nxt, plane_r[front_sel_nxt][comm_nxt]);
      led_g       <= col_drive(enable_nxt, plane_g[front_sel_nxt][comm_nxt]);
      led_b       <= col_drive(enable_nxt, plane_b[front_sel_nxt][comm_nxt]);
    end
  end

  assign bus.swap_ack    = swap_ack;
  assign bus.frame_start = frame_start;
  assign bus.comm        = comm;
  assign bus.enable      = enable;
  assign bus.LedR        = led_r;
  assign bus.LedG        = led_g;
  assign bus.LedB        = led_b;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Testbench for led_matrix_scanner: per-cycle scoreboard against a behavioural
// frame model, plus table-driven single-cell frames and handshake corner cases.
module tb_led_matrix_scanner;
  localparam int RT = 8;
  localparam int BT = 2;

  typedef struct packed {
    logic       ack;
    logic       fs;
    logic [2:0] comm;
    logic       en;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  typedef struct {
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] rgb;
    logic [7:0] er;
    logic [7:0] eg;
    logic [7:0] eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_matrix_scanner_if bus();

  led_matrix_scanner #(.ROW_TICKS(RT), .BLANK_TICKS(BT)) dut (
    .SYS_CLK(clk),
    .RST    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs [5];
  exp_t exp_q [$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ack_seen = 0;
  int   fs_n = 0;
  int   fs_cyc [2];

  logic [2:0] m_buf [2][8][8];
  int         m_cnt;
  int         m_comm;
  logic       m_front;
  logic       m_pend;

  task automatic model_edge(output exp_t e);
    logic bnd;
    logic sw;
    int   bk;
    e = '0;
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) m_buf[k][r][c] = 3'b000;
      m_cnt = 0; m_comm = 0; m_front = 1'b0; m_pend = 1'b0;
      e.r = 8'hFF; e.g = 8'hFF; e.b = 8'hFF;
    end else begin
      bk = m_front ? 0 : 1;
      if (bus.clr)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) m_buf[bk][r][c] = 3'b000;
      if (bus.wr_en) m_buf[bk][bus.wr_x][bus.wr_y] = bus.wr_rgb;
      bnd = (m_cnt == RT - 1) && (m_comm == 7);
      sw  = bnd && (m_pend || bus.swap_req);
      if (bnd) m_pend = 1'b0;
      else if (bus.swap_req) m_pend = 1'b1;
      if (sw) m_front = ~m_front;
      if (m_cnt == RT - 1) begin
        m_cnt  = 0;
        m_comm = (m_comm + 1) % 8;
      end else begin
        m_cnt = m_cnt + 1;
      end
      e.ack  = sw;
      e.fs   = bnd;
      e.comm = 3'(m_comm);
      e.en   = (m_cnt >= BT);
      for (int y = 0; y < 8; y++) begin
        e.r[y] = e.en ? ~m_buf[m_front][m_comm][y][2] : 1'b1;
        e.g[y] = e.en ? ~m_buf[m_front][m_comm][y][1] : 1'b1;
        e.b[y] = e.en ? ~m_buf[m_front][m_comm][y][0] : 1'b1;
      end
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, got, want);
    end
  endtask

  task automatic check24(input string nm, input logic [23:0] got, input logic [23:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got RGB %h, want %h", nm, cyc, got, want);
    end
  endtask

  // One clock: predict, advance, then pop the prediction and compare.
  task automatic tick();
    exp_t e;
    exp_t got;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    last_exp = exp_q.pop_front();
    got = {bus.swap_ack, bus.frame_start, bus.comm, bus.enable, bus.LedR, bus.LedG, bus.LedB};
    n_cmp++;
    if (got !== last_exp) begin
      n_bad++;
      $display("FAIL scoreboard @cyc %0d: got %h, want %h", cyc, got, last_exp);
    end
    if (bus.swap_ack === 1'b1) ack_seen++;
    if (bus.frame_start === 1'b1 && fs_n < 2) begin
      fs_cyc[fs_n] = cyc;
      fs_n++;
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_x = 3'd0; bus.wr_y = 3'd0; bus.wr_rgb = 3'd0;
    bus.clr = 1'b0; bus.swap_req = 1'b0;
  endtask

  task automatic wait_row(input int row, input int cntv);
    int i;
    i = 0;
    while (!(m_comm == row && m_cnt == cntv) && i < 200) begin
      tick();
      i++;
    end
    check_int("wait_row_reached", (m_comm == row && m_cnt == cntv) ? 1 : 0, 1);
  endtask

  task automatic wait_swap();
    logic hit;
    hit = last_exp.ack;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      hit = last_exp.ack;
    end
    if (!hit) begin
      n_cmp++; n_bad++;
      $display("FAIL swap_timeout @cyc %0d: got no swap, want swap within 200 cycles", cyc);
    end else begin
      check_int("swap_ack_pulse", int'(bus.swap_ack), 1);
      check_int("swap_with_frame_start", int'(bus.frame_start), 1);
    end
  endtask

  task automatic check_frame(input logic [2:0] x, input logic [7:0] er,
                             input logic [7:0] eg, input logic [7:0] eb);
    logic [23:0] want;
    repeat (RT * 8) begin
      tick();
      want = (last_exp.en && last_exp.comm == x) ? {er, eg, eb} : 24'hFFFFFF;
      check24("frame_row", {bus.LedR, bus.LedG, bus.LedB}, want);
    end
  endtask

  task automatic load_and_swap(input logic [2:0] x, input logic [2:0] y, input logic [2:0] rgb);
    bus.clr = 1'b1; bus.wr_en = 1'b1;
    bus.wr_x = x; bus.wr_y = y; bus.wr_rgb = rgb;
    bus.swap_req = 1'b1;
    tick();
    idle_inputs();
    wait_swap();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd3, 3'd5, 3'b100, 8'hDF, 8'hFF, 8'hFF};
    vecs[1] = '{3'd0, 3'd0, 3'b010, 8'hFF, 8'hFE, 8'hFF};
    vecs[2] = '{3'd7, 3'd7, 3'b001, 8'hFF, 8'hFF, 8'h7F};
    vecs[3] = '{3'd5, 3'd2, 3'b111, 8'hFB, 8'hFB, 8'hFB};
    vecs[4] = '{3'd2, 3'd1, 3'b011, 8'hFF, 8'hFD, 8'hFD};
    idle_inputs();

    // Reset and free run
    rst = 1'b1;
    tick();
    tick();
    check_int("rst_comm", int'(bus.comm), 0);
    check_int("rst_enable", int'(bus.enable), 0);
    check24("rst_leds", {bus.LedR, bus.LedG, bus.LedB}, 24'hFFFFFF);
    check_int("rst_ack_fs", int'({bus.swap_ack, bus.frame_start}), 0);
    rst = 1'b0;
    cyc = 0;
    fs_n = 0;
    repeat (130) begin
      tick();
      check24("freerun_blank", {bus.LedR, bus.LedG, bus.LedB}, 24'hFFFFFF);
    end
    check_int("first_frame_start", fs_cyc[0], 64);
    check_int("second_frame_start", fs_cyc[1], 128);

    // Single-cell write and swap, table driven
    for (int v = 0; v < 5; v++) begin
      load_and_swap(vecs[v].x, vecs[v].y, vecs[v].rgb);
      check_frame(vecs[v].x, vecs[v].er, vecs[v].eg, vecs[v].eb);
    end

    // Repeated requests within one frame yield one swap
    wait_row(1, 0);
    ack_seen = 0;
    bus.swap_req = 1'b1;
    repeat (20) tick();
    bus.swap_req = 1'b0;
    repeat (140) tick();
    check_int("repeated_req_acks", ack_seen, 1);

    // Request only on the boundary edge: immediate swap, nothing a frame later
    wait_row(7, RT - 1);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    check_int("boundary_req_ack", int'(bus.swap_ack), 1);
    ack_seen = 0;
    check_frame(vecs[4].x, vecs[4].er, vecs[4].eg, vecs[4].eb);
    check_int("boundary_no_second_swap", ack_seen, 0);

    // Second swap brings the previous frame back (no copy on swap)
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    wait_swap();
    check_frame(vecs[3].x, vecs[3].er, vecs[3].eg, vecs[3].eb);

    // clr plus write over a full back buffer
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        bus.wr_en = 1'b1; bus.wr_x = 3'(r); bus.wr_y = 3'(c); bus.wr_rgb = 3'b111;
        tick();
      end
    end
    idle_inputs();
    load_and_swap(3'd0, 3'd0, 3'b010);
    check_frame(3'd0, 8'hFF, 8'hFE, 8'hFF);

    // Mid-frame reset with a swap pending
    wait_row(4, 0);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    wait_row(5, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_int("midrst_comm", int'(bus.comm), 0);
    check_int("midrst_enable", int'(bus.enable), 0);
    check24("midrst_leds", {bus.LedR, bus.LedG, bus.LedB}, 24'hFFFFFF);
    check_int("midrst_ack_fs", int'({bus.swap_ack, bus.frame_start}), 0);
    ack_seen = 0;
    repeat (70) begin
      tick();
      check24("midrst_blank", {bus.LedR, bus.LedG, bus.LedB}, 24'hFFFFFF);
    end
    check_int("midrst_no_ack", ack_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Downstream display stage for the 8×8 RGB snake board. Holds a double-buffered 8×8 RGB frame. Game logic writes cells into the back buffer and requests a swap. The block scans the front buffer one row at a time onto the active-low `LedR`/`LedG`/`LedB` column lines, the `comm` row select and `enable`. Each row starts with a blanking interval to suppress ghosting. Buffer swaps happen only at frame boundaries, so the game never shows a half-updated map.

## Interface
- `ROW_TICKS`, default 50000: clock cycles each row is held. Must be ≥ 2.
- `BLANK_TICKS`, default 16: cycles at the start of each row during which the display is blanked. Must satisfy 1 ≤ `BLANK_TICKS` < `ROW_TICKS`.

- `SYS_CLK` in 1: system clock. This is the only clock.
- `RST` in 1: reset, synchronous, active-high.
- `wr_en` in 1: write one cell of the back buffer.
- `wr_x` in 3: row index (the `comm` value) of the cell.
- `wr_y` in 3: column index, i.e. the `Led*` bit position.
- `wr_rgb` in 3: {R,G,B}, 1 = lit.
- `clr` in 1: clear all 64 cells of the back buffer in one cycle.
- `swap_req` in 1: request a front/back swap at the next frame boundary.
- `swap_ack` out 1: one-cycle pulse on the cycle the swap takes effect.
- `frame_start` out 1: one-cycle pulse on the first cycle of row 0.
- `comm` out 3: current row select.
- `enable` out 1: 1 = row driven, 0 = blanked.
- `LedR`, `LedG`, `LedB` out 8 each: active-low column drive. Bit y = column y.

## Operation
- Storage: two buffers of 8 rows × 8 columns × 3 colours. A `front_sel` register selects which buffer is displayed; the other buffer is the back buffer.
- Scan counter `cnt` runs 0..`ROW_TICKS`-1. When `cnt` = `ROW_TICKS`-1, `cnt` wraps to 0 and `comm` advances mod 8 (7 wraps to 0).
- Row cycle k, where k is the `cnt` value of the cycle:
  - k < `BLANK_TICKS`: `enable`=0 and `LedR`/`LedG`/`LedB` = 8'hFF.
  - Otherwise: `enable`=1, `LedR` = ~front[comm].R plane, and likewise for G and B.
- Outputs are registered, and their values are coherent with `comm` and `cnt` in the same cycle.
- Writes always target the back buffer as selected by `front_sel` before any swap in that cycle. The front buffer is never written.
- `clr` and `wr_en` in the same cycle: the clear applies first, then the write. Only the written cell ends up lit.
- Swap handshake:
  - `swap_req`=1 in any cycle sets `pending`. Holding it high or pulsing it repeatedly before a boundary yields exactly one swap.
  - Frame boundary = the cycle in which `comm` becomes 0 from 7.
  - At a boundary with `pending` set, or with `swap_req`=1 in that same cycle: `front_sel` toggles, `pending` clears, and `swap_ack`=1.
  - A `swap_req` asserted on the boundary cycle is consumed by that swap and does not set `pending` again.
- No copy is made on swap. The new back buffer holds the previous front content.
- `frame_start`=1 exactly on boundary cycles, whether or not a swap occurs.

## Timing
- Reset values, asserted on the cycle after `RST` is sampled high:
  - `comm`=0, `cnt`=0, `enable`=0, `LedR`/`LedG`/`LedB`=8'hFF.
  - `swap_ack`=0, `frame_start`=0, `front_sel`=0, `pending`=0.
  - Both buffers cleared.
- `RST` overrides all other inputs, including mid-frame and with a swap pending. The pending request is discarded.
- Write latency: one cycle into the back buffer. The cell becomes visible only after a swap.
- Swap-to-display latency: a swap takes effect on the boundary cycle. Row 0 of the new front appears at `enable`=1, i.e. `BLANK_TICKS` cycles after the boundary. The blanking guarantees no torn row.
- Frame period: 8 × `ROW_TICKS` cycles. The first `frame_start` comes 8 × `ROW_TICKS` cycles after reset release.
- Counter width: ceil(log2(`ROW_TICKS`)) bits. There are no other arithmetic constraints.

## Test plan
All tests use `ROW_TICKS`=8 and `BLANK_TICKS`=2.
- **Reset and free run:**
  - Stimulus: release `RST`, no other stimulus.
  - Required: `comm` steps 0..7 and then back to 0, changing every 8 cycles.
  - Required: `enable` is 0 for 2 cycles and then 1 for 6 cycles in every row.
  - Required: all `Led*` lines stay 8'hFF throughout.
  - Required: `frame_start` pulses at cycle 64, 128, and so on.
- **Single-cell write and swap:**
  - Stimulus: write (x=3, y=5, rgb=3'b100), then pulse `swap_req`.
  - Required: `swap_ack` pulses together with the next `frame_start`.
  - Required: while `comm`=3 and `enable`=1, `LedR`=8'b11011111 and `LedG`/`LedB`=8'hFF.
  - Required: all other rows drive 8'hFF.
- **Repeated requests:**
  - Stimulus: hold `swap_req` high for 20 cycles within one frame.
  - Required: exactly one `swap_ack`, and no swap at the following boundary.
- **Boundary request and no-copy check:**
  - Stimulus: assert `swap_req` only on a boundary cycle.
  - Required: immediate `swap_ack`, and no swap one frame later.
  - Stimulus: perform a second swap.
  - Required: the previous frame's content returns to the display.
- **clr plus wr:**
  - Stimulus: with the back buffer full (all cells 3'b111), assert `clr` and a write of (0, 0, 3'b010) in the same cycle, then swap.
  - Required: in row 0, `LedG`=8'b11111110.
  - Required: every other `Led*` value is 8'hFF.
- **Mid-frame reset:**
  - Stimulus: assert `RST` while `comm`=5 with `pending` set.
  - Required: the next cycle shows the reset values.
  - Required: no `swap_ack` at the following boundary.
  - Required: the display stays blank.
